// File: rtl/heartbeat_sequencer.sv
// Lub-dub heartbeat on an 8-LED one-hot ring: a tick prescaler steps an envelope FSM,
// and a free-running PWM turns the envelope level into duty on the active LED.
module heartbeat_sequencer #(
    parameter int TICK_DIV  = 100,
    parameter int PEAK1     = 15,
    parameter int PEAK2     = 8,
    parameter int GAP_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       dir,
    input  logic [7:0] rest_ticks,
    output logic [7:0] led,
    output logic [3:0] level,
    output logic       busy,
    output logic       beat_done
);

    localparam int PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);
    localparam int HOLD_W = (GAP_W > 8) ? GAP_W : 8;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] GAP_LAST = HOLD_W'(GAP_TICKS - 1);
    localparam logic [3:0]        PEAK1_L  = 4'(PEAK1);
    localparam logic [3:0]        PEAK2_L  = 4'(PEAK2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RISE1 = 3'd1,
        ST_FALL1 = 3'd2,
        ST_GAP   = 3'd3,
        ST_RISE2 = 3'd4,
        ST_FALL2 = 3'd5,
        ST_REST  = 3'd6
    } state_t;

    logic [PRE_W-1:0]  pre_cnt_r;
    logic              tick_s;
    logic [3:0]        pwm_cnt_r;
    state_t            state_r;
    logic [HOLD_W-1:0] hold_r;
    logic [7:0]        rest_len_r;
    logic [7:0]        pos_r;
    logic [3:0]        level_up_s;
    logic [3:0]        level_dn_s;
    logic [HOLD_W-1:0] rest_last_s;

    function automatic logic [7:0] rotate_pos(input logic [7:0] p, input logic d);
        logic [7:0] r;
        if (d) begin
            r = {p[0], p[7:1]};
        end else begin
            r = {p[6:0], p[7]};
        end
        return r;
    endfunction

    assign tick_s      = (pre_cnt_r == PRE_LAST);
    assign level_up_s  = level + 4'd1;
    assign level_dn_s  = level - 4'd1;
    // rest_len_r is never 0, so the subtraction cannot underflow
    assign rest_last_s = HOLD_W'(rest_len_r - 8'd1);

    // Free-running tick prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        end
    end

    // PWM counter and registered LED drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= 4'd0;
            led       <= 8'd0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 4'd1;
            led       <= pos_r & {8{level > pwm_cnt_r}};
        end
    end

    // Envelope FSM: level, hold counters, ring position, busy and beat_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            level      <= 4'd0;
            hold_r     <= '0;
            rest_len_r <= 8'd1;
            pos_r      <= 8'b0000_0001;
            busy       <= 1'b0;
            beat_done  <= 1'b0;
        end else begin
            beat_done <= 1'b0;
            if (tick_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (enable) begin
                            state_r <= ST_RISE1;
                            busy    <= 1'b1;
                        end else begin
                            busy    <= 1'b0;
                        end
                    end
                    ST_RISE1: begin
                        level <= level_up_s;
                        if (level_up_s == PEAK1_L) begin
                            state_r <= ST_FALL1;
                        end
                    end
                    ST_FALL1: begin
                        level <= level_dn_s;
                        if (level_dn_s == 4'd0) begin
                            state_r <= ST_GAP;
                            hold_r  <= '0;
                        end
                    end
                    ST_GAP: begin
                        if (hold_r == GAP_LAST) begin
                            state_r <= ST_RISE2;
                            hold_r  <= '0;
                        end else begin
                            hold_r  <= hold_r + HOLD_W'(1);
                        end
                    end
                    ST_RISE2: begin
                        level <= level_up_s;
                        if (level_up_s == PEAK2_L) begin
                            state_r <= ST_FALL2;
                        end
                    end
                    ST_FALL2: begin
                        level <= level_dn_s;
                        if (level_dn_s == 4'd0) begin
                            state_r    <= ST_REST;
                            hold_r     <= '0;
                            rest_len_r <= (rest_ticks == 8'd0) ? 8'd1 : rest_ticks;
                        end
                    end
                    ST_REST: begin
                        if (hold_r == rest_last_s) begin
                            beat_done <= 1'b1;
                            pos_r     <= rotate_pos(pos_r, dir);
                            hold_r    <= '0;
                            busy      <= enable;
                            state_r   <= enable ? ST_RISE1 : ST_IDLE;
                        end else begin
                            hold_r    <= hold_r + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        level   <= 4'd0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// Directed bench for heartbeat_sequencer: a table of beats with hand-computed
// lengths and ring positions, plus hand-written idle, re-enable, reset and PWM sequences.
module tb_heartbeat_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, enable, dir;
    logic [7:0] rest_ticks;
    logic [7:0] led;
    logic [3:0] level;
    logic       busy, beat_done;

    logic       rst_n2, enable2;
    logic [7:0] led2;
    logic [3:0] level2;
    logic       busy2, beat_done2;

    int n_checks = 0;
    int n_fail   = 0;

    heartbeat_sequencer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir), .rest_ticks(rest_ticks),
        .led(led), .level(level), .busy(busy), .beat_done(beat_done)
    );

    heartbeat_sequencer #(.TICK_DIV(32)) dut_pwm (
        .clk(clk), .rst_n(rst_n2), .enable(enable2), .dir(1'b0), .rest_ticks(8'd0),
        .led(led2), .level(level2), .busy(busy2), .beat_done(beat_done2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic [7:0] rest;
        int         chg_at;
        logic [7:0] chg_val;
        int         ticks;
        logic [7:0] pos;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Envelope level k ticks into a beat at PEAK1=15, GAP_TICKS=4, PEAK2=8
    function automatic logic [31:0] exp_level(input int k);
        if (k <= 0)       return 32'd0;
        else if (k <= 15) return 32'(k);
        else if (k <= 30) return 32'(30 - k);
        else if (k <= 34) return 32'd0;
        else if (k <= 42) return 32'(k - 34);
        else if (k <= 50) return 32'(50 - k);
        else              return 32'd0;
    endfunction

    task automatic beat_loop(input bit prof, input int drop_at, input int chg_at,
                             input logic [7:0] chg_val, output int c, output logic [7:0] lor);
        bit done;
        done = 1'b0;
        c    = 0;
        lor  = 8'd0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
            lor = lor | led;
            if (c == drop_at) enable = 1'b0;
            if (c == chg_at) rest_ticks = chg_val;
            if (beat_done) done = 1'b1;
            if (prof && (c % 4 == 0)) begin
                check($sformatf("level_at_tick_%0d", c / 4), 32'(level), exp_level(c / 4));
                if (!done) check("busy_in_beat", 32'(busy), 32'd1);
            end
        end
        if (!done) check("beat_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic pwm_duty(input logic [3:0] lv, input string nm);
        int cnt;
        int waited;
        logic [7:0] others;
        waited = 0;
        while (level2 !== lv && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        check({nm, "_reached"}, 32'(level2), 32'(lv));
        @(negedge clk);
        cnt    = 0;
        others = 8'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led2[0]) cnt++;
            others = others | (led2 & 8'hFE);
        end
        check({nm, "_duty"}, 32'(cnt), 32'(lv));
        check({nm, "_other_leds"}, 32'(others), 32'd0);
    endtask

    initial begin
        int c;
        int w;
        logic [7:0] lor;

        //           dir   rest    chg_at chg_val ticks pos
        vecs[0]  = '{1'b1, 8'd10,  0,   8'd0, 60,  8'h80};
        vecs[1]  = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h40};
        vecs[2]  = '{1'b0, 8'd3,   0,   8'd0, 53,  8'h80};
        vecs[3]  = '{1'b0, 8'd255, 0,   8'd0, 305, 8'h01};
        vecs[4]  = '{1'b1, 8'd1,   0,   8'd0, 51,  8'h02};
        vecs[5]  = '{1'b1, 8'd6,   204, 8'd1, 56,  8'h01};
        vecs[6]  = '{1'b0, 8'd1,   0,   8'd0, 51,  8'h80};
        vecs[7]  = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h01};
        vecs[8]  = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h02};
        vecs[9]  = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h04};
        vecs[10] = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h08};
        vecs[11] = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h10};
        vecs[12] = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h20};
        vecs[13] = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h40};
        vecs[14] = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h80};
        vecs[15] = '{1'b0, 8'd0,   0,   8'd0, 51,  8'h01};

        rst_n = 1'b0; enable = 1'b0; dir = 1'b0; rest_ticks = 8'd10;
        rst_n2 = 1'b0; enable2 = 1'b1;

        // Reset values, then 1000 idle clocks with enable low
        repeat (3) @(negedge clk);
        check("reset_outputs", {18'd0, led, level, busy, beat_done}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check("idle_outputs", {18'd0, led, level, busy, beat_done}, 32'd0);
        end

        // First beat from reset with dir=1: IDLE waits one tick, then 60 ticks
        rst_n = 1'b0;
        @(negedge clk);
        dir = 1'b1; rest_ticks = 8'd10; enable = 1'b1; rst_n = 1'b1;
        beat_loop(1'b0, 0, 0, 8'd0, c, lor);
        check("first_beat_clks", 32'(c), 32'd244);
        check("first_beat_pos", 32'(lor), 32'h01);

        for (int i = 0; i < 16; i++) begin
            dir = vecs[i].d;
            rest_ticks = vecs[i].rest;
            beat_loop(1'b1, 0, vecs[i].chg_at, vecs[i].chg_val, c, lor);
            check($sformatf("beat_clks[%0d]", i), 32'(c), 32'(vecs[i].ticks * 4));
            check($sformatf("beat_pos[%0d]", i), 32'(lor), 32'(vecs[i].pos));
        end

        // enable dropped in RISE2: beat completes and rotates, then IDLE
        dir = 1'b0; rest_ticks = 8'd2;
        beat_loop(1'b1, 144, 0, 8'd0, c, lor);
        check("drop_beat_clks", 32'(c), 32'd208);
        check("drop_beat_pos", 32'(lor), 32'h02);
        check("drop_busy_at_end", 32'(busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("stopped_outputs", {19'd0, led, level, busy}, 32'd0);
        end
        enable = 1'b1;
        w = 0;
        while (!busy && w < 12) begin
            @(negedge clk);
            w++;
        end
        check("restart_clks", 32'(w), 32'd4);
        check("restart_level", 32'(level), 32'd0);
        beat_loop(1'b1, 0, 0, 8'd0, c, lor);
        check("restart_beat_clks", 32'(c), 32'd208);
        check("restart_beat_pos", 32'(lor), 32'h04);

        // Async reset in the middle of FALL1 clears everything, ring restarts at bit 0
        for (int i = 0; i < 80; i++) @(negedge clk);
        check("fall1_level", 32'(level), 32'd10);
        #2 rst_n = 1'b0;
        #1 check("midbeat_reset_outputs", {18'd0, led, level, busy, beat_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat_loop(1'b0, 0, 0, 8'd0, c, lor);
        check("post_reset_beat_clks", 32'(c), 32'd212);
        check("post_reset_beat_pos", 32'(lor), 32'h01);

        // PWM duty on the slow instance
        @(negedge clk);
        rst_n2 = 1'b1;
        pwm_duty(4'd15, "pwm15");
        pwm_duty(4'd4, "pwm4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
